kernel_mac_engine: RTL and testbench
====================================

# kernel_mac_engine

Parametrised multi-tap multiply-accumulate engine for the image-processing convolution path. It streams one pixel/coefficient pair per cycle, accumulates a full kernel window (e.g. 9 taps for 3×3) in a pipelined multiplier/accumulator, then rounds, scales and optionally saturates the sum to pixel width. It sits between the line-buffer window generator and the output pixel formatter, and replaces the fixed single-tap 16×16 MAC.

## Interface
- `DATA_W`, 16: signed pixel operand width.
- `COEF_W`, 16: signed coefficient width.
- `TAPS`, 9: products per output group; legal range is 1..256.
- `ACC_W`, 37: accumulator width; must be ≥ DATA_W+COEF_W+clog2(TAPS).
- `SHIFT`, 8: right shift applied to the accumulator before output; 0 disables rounding.
- `OUT_W`, 16: signed output width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input tap valid.
- `in_ready`  out  1  engine accepts a tap this cycle.
- `in_data`  in  DATA_W  signed pixel.
- `in_coef`  in  COEF_W  signed coefficient.
- `in_last`  in  1  marks the final tap of a group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  OUT_W  rounded, scaled result.
- `out_err`  out  1  group-length mismatch flag, qualified by out_valid.

## Operation
- A tap is accepted when `in_valid && in_ready`.
- Pipeline, all stages gated by a common enable `en = !(out_valid && !out_ready)`:
  - S1 registers data, coef, last and a valid bit.
  - S2 computes the full-precision signed product (DATA_W+COEF_W bits).
  - S3 is the accumulator plus tap counter.
- Accumulator FSM, two states:
  - ACC_IDLE: tap_cnt = 0, acc = 0.
  - ACC_RUN: tap_cnt ≥ 1.
  - On the first valid S2 product: acc = product (not acc + product). Go to ACC_RUN, or close the group immediately if the close condition holds (covers TAPS = 1).
  - Subsequent products: acc += sign-extended product, tap_cnt++.
  - Close condition: last flag set OR tap_cnt == TAPS-1. On close, load the output register and return to ACC_IDLE.
- `out_err` = 1 when the group closed on the count without `last`, or on `last` before the count reached TAPS-1.
- Output arithmetic, in ACC_W+1 bits:
  - r = (acc + (SHIFT ? 1<<(SHIFT-1) : 0)) >>> SHIFT. This rounds half toward +inf.
  - r is then reduced to OUT_W as described under Configuration.
- `in_ready = en`, combinational from `out_ready`. While the engine is stalled, every stage, the counter and the FSM hold.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_err`=0, all pipeline valids 0, acc=0, tap_cnt=0, FSM=ACC_IDLE. `in_ready`=1 during and after reset.
- Reset is asynchronous mid-group: any partial accumulation and any pending output are discarded.
- Latency: final tap accepted in cycle t → `out_valid`=1 in cycle t+3.
- Throughput: one tap per cycle. Back-to-back groups need no bubble; a new group's first tap may follow the previous `in_last` directly.
- `out_valid` holds with stable `out_data`/`out_err` until `out_ready`. A closing group and `out_ready` in the same cycle replaces the output register without a bubble.
- Empty input cycles (in_valid=0) create bubbles that do not advance tap_cnt.

## Configuration
- `KERNEL_MAC_SATURATE_EN` defined: r is clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Undefined: r is truncated to its low OUT_W bits (two's-complement wrap), which needs no comparator logic.

## Structure
- Package `kernel_mac_pkg`:
  - accumulator FSM state enum.
  - function `clog2`.
  - rounding/saturation function `mac_round_sat`, with the macro inside the function.
- Sub-module `mac_mult_stage`: the S1/S2 registered signed multiplier with enable and valid. It stays a separate module so it maps onto one DSP48E1 (A/B reg + M reg).

## Test plan
- TAPS=3, SHIFT=0. Data 1,2,3 with coef 4,5,6, `in_last` on the third tap → `out_data`=32, `out_err`=0, 3 cycles after the last tap.
- Defaults. Acc 384 → `out_data`=2; acc −384 → `out_data`=−1 (rounding check).
- Defaults. Nine taps of 32767×32767 → 32767 with `KERNEL_MAC_SATURATE_EN`, −2304 without.
- Defaults. `in_last` on the 5th tap → output after 5 taps with `out_err`=1. Nine taps without `in_last` → output with `out_err`=1.
- Two back-to-back groups with `out_ready` low for 4 cycles after the first result → `in_ready` low those 4 cycles, first result held stable, both results correct, no tap lost.
- `rst_n` pulsed low after 4 taps → all outputs 0. The next 9-tap group yields a result with no contribution from the aborted taps.

Source files
------------

// File: rtl/kernel_mac_pkg.sv
// kernel_mac_pkg: shared types and arithmetic helpers for kernel_mac_engine.
// Optional feature macro: KERNEL_MAC_SATURATE_EN. When it is defined, results
// are clamped to the output range. Otherwise the caller keeps the low OUT_W
// bits, which wraps in two's complement.
package kernel_mac_pkg;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

    // Working width of the rounding helper. It must be at least ACC_W+1.
    localparam int MAC_CALC_W = 128;

    // Ceiling log2. Returns 0 for an input of 1 or less.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Round half toward +inf, shift right arithmetically, and optionally clamp
    // to a signed out_w range. The caller truncates the result to out_w bits.
    function automatic logic signed [MAC_CALC_W-1:0] mac_round_sat(
        input logic signed [MAC_CALC_W-1:0] acc_val,
        input int                           shift,
        input int                           out_w
    );
        logic signed [MAC_CALC_W-1:0] one_v;
        logic signed [MAC_CALC_W-1:0] rnd_v;
        logic signed [MAC_CALC_W-1:0] r_v;
`ifdef KERNEL_MAC_SATURATE_EN
        logic signed [MAC_CALC_W-1:0] max_v;
        logic signed [MAC_CALC_W-1:0] min_v;
`endif
        one_v = {{(MAC_CALC_W-1){1'b0}}, 1'b1};
        if (shift > 0) begin
            rnd_v = one_v <<< (shift - 1);
        end else begin
            rnd_v = {MAC_CALC_W{1'b0}};
        end
        r_v = (acc_val + rnd_v) >>> shift;
`ifdef KERNEL_MAC_SATURATE_EN
        max_v = (one_v <<< (out_w - 1)) - one_v;
        min_v = -(one_v <<< (out_w - 1));
        if (r_v > max_v) begin
            r_v = max_v;
        end else if (r_v < min_v) begin
            r_v = min_v;
        end else begin
            r_v = r_v;
        end
`else
        // Wrap mode: the caller keeps the low out_w bits, so no comparator is needed.
        if (out_w <= 0) begin
            r_v = {MAC_CALC_W{1'b0}};
        end else begin
            r_v = r_v;
        end
`endif
        return r_v;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: S1 operand registers and S2 product register of the MAC
// pipeline. It is kept as its own module so that it maps onto a single DSP
// slice (A/B register followed by M register). All registers hold while
// en is low.
module mac_mult_stage
    import kernel_mac_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic signed [A_W-1:0]  in_a,
    input  logic signed [B_W-1:0]  in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic signed [A_W+B_W-1:0] out_prod,
    output logic                   out_last
);

    localparam int P_W = A_W + B_W;

    logic signed [A_W-1:0] a_q, a_d;
    logic signed [B_W-1:0] b_q, b_d;
    logic                  last1_q, last1_d;
    logic                  valid1_q, valid1_d;
    logic signed [P_W-1:0] prod_q, prod_d;
    logic                  last2_q, last2_d;
    logic                  valid2_q, valid2_d;

    // Next-state logic: advance both stages only when the pipeline is enabled.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        last1_d  = last1_q;
        valid1_d = valid1_q;
        prod_d   = prod_q;
        last2_d  = last2_q;
        valid2_d = valid2_q;
        if (en) begin
            a_d      = in_a;
            b_d      = in_b;
            last1_d  = in_last;
            valid1_d = in_valid;
            prod_d   = P_W'(a_q) * P_W'(b_q);
            last2_d  = last1_q;
            valid2_d = valid1_q;
        end else begin
            valid1_d = valid1_q;
        end
    end

    // Pipeline registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= {A_W{1'b0}};
            b_q      <= {B_W{1'b0}};
            last1_q  <= 1'b0;
            valid1_q <= 1'b0;
            prod_q   <= {P_W{1'b0}};
            last2_q  <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            last1_q  <= last1_d;
            valid1_q <= valid1_d;
            prod_q   <= prod_d;
            last2_q  <= last2_d;
            valid2_q <= valid2_d;
        end
    end

    assign out_valid = valid2_q;
    assign out_prod  = prod_q;
    assign out_last  = last2_q;

endmodule

// File: rtl/kernel_mac_engine.sv
// kernel_mac_engine: streaming multi-tap MAC for the convolution path.
// It accumulates TAPS products, or fewer if in_last arrives early, then
// rounds, shifts and reduces the sum to OUT_W.
// Optional feature macro: KERNEL_MAC_SATURATE_EN (clamp instead of wrap).
module kernel_mac_engine
    import kernel_mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 9,
    parameter int ACC_W  = 37,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_err
);

    localparam int P_W   = DATA_W + COEF_W;
    localparam int CNT_W = (TAPS > 1) ? clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    logic                   en_s;
    logic                   prod_valid_s;
    logic signed [P_W-1:0]  prod_s;
    logic                   prod_last_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_sum_s;
    logic                   at_count_s;
    logic                   close_s;
    logic signed [MAC_CALC_W-1:0] round_full_s;
    logic                   round_unused_s;

    acc_state_e              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_err_q, out_err_d;

    // Whole pipeline stalls only when a result is waiting and not taken.
    assign en_s     = !(out_valid_q && !out_ready);
    assign in_ready = en_s;

    mac_mult_stage #(
        .A_W (DATA_W),
        .B_W (COEF_W)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_s),
        .in_valid  (in_valid),
        .in_a      (in_data),
        .in_b      (in_coef),
        .in_last   (in_last),
        .out_valid (prod_valid_s),
        .out_prod  (prod_s),
        .out_last  (prod_last_s)
    );

    // Accumulate, decide group close, and compute the rounded candidate result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_cnt_d   = tap_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        close_s     = 1'b0;

        prod_ext_s = ACC_W'(prod_s);
        at_count_s = (tap_cnt_q == LAST_CNT);

        case (state_q)
            ACC_IDLE: acc_sum_s = prod_ext_s;
            ACC_RUN:  acc_sum_s = acc_q + prod_ext_s;
            default:  acc_sum_s = prod_ext_s;
        endcase

        round_full_s   = mac_round_sat(MAC_CALC_W'(acc_sum_s), SHIFT, OUT_W);
        round_unused_s = ^round_full_s[MAC_CALC_W-1:OUT_W];

        if (en_s) begin
            // When enabled, any pending result is consumed this cycle.
            out_valid_d = 1'b0;
            if (prod_valid_s) begin
                close_s = prod_last_s || at_count_s;
                if (close_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = round_full_s[OUT_W-1:0];
                    // Error if exactly one of the two close reasons is present.
                    out_err_d   = prod_last_s ^ at_count_s;
                    state_d     = ACC_IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    tap_cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d   = ACC_RUN;
                    acc_d     = acc_sum_s;
                    tap_cnt_d = tap_cnt_q + CNT_W'(1);
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator, counter, FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            tap_cnt_q   <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_cnt_q   <= tap_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_kernel_mac_engine.sv
// Self-checking bench for kernel_mac_engine. It compares the DUT against a
// queue-based arithmetic reference model, and drives a small TAPS=3 instance
// for the latency case.
module tb_kernel_mac_engine;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 9;
    localparam int SHIFT  = 8;
    localparam int OUT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     in_valid, in_ready, in_last;
    logic signed [DATA_W-1:0] in_data;
    logic signed [COEF_W-1:0] in_coef;
    logic                     out_valid, out_ready, out_err;
    logic signed [OUT_W-1:0]  out_data;

    logic                     in_valid3, in_ready3, in_last3;
    logic signed [DATA_W-1:0] in_data3;
    logic signed [COEF_W-1:0] in_coef3;
    logic                     out_valid3, out_ready3, out_err3;
    logic signed [OUT_W-1:0]  out_data3;

    kernel_mac_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(37), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_coef(in_coef), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    kernel_mac_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(3), .ACC_W(37), .SHIFT(0), .OUT_W(OUT_W)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_coef(in_coef3), .in_last(in_last3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_err(out_err3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: per-group sum of products and a queue of expected results.
    longint exp_data_q[$];
    bit     exp_err_q[$];
    longint m_sum = 0;
    int     m_cnt = 0;
    int     stall_left = 0;

    function automatic longint ref_result(input longint sum, input int shift, input int out_w);
        longint r;
        r = sum;
        if (shift > 0) r = r + (longint'(1) <<< (shift - 1));
        r = r >>> shift;
`ifdef KERNEL_MAC_SATURATE_EN
        if (r > (longint'(1) <<< (out_w - 1)) - 1) r = (longint'(1) <<< (out_w - 1)) - 1;
        else if (r < -(longint'(1) <<< (out_w - 1))) r = -(longint'(1) <<< (out_w - 1));
`else
        r = (r <<< (64 - out_w)) >>> (64 - out_w);
`endif
        return r;
    endfunction

    task automatic model_tap(input logic signed [DATA_W-1:0] d, input logic signed [COEF_W-1:0] c,
                             input logic l);
        m_sum = m_sum + longint'(d) * longint'(c);
        m_cnt = m_cnt + 1;
        if (l || m_cnt == TAPS) begin
            exp_data_q.push_back(ref_result(m_sum, SHIFT, OUT_W));
            exp_err_q.push_back(!(l && m_cnt == TAPS));
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    // One clock of stimulus plus output scoreboarding.
    task automatic step(input logic v, input logic signed [DATA_W-1:0] d,
                        input logic signed [COEF_W-1:0] c, input logic l,
                        input logic ordy, output logic accepted);
        logic stalled;
        @(negedge clk);
        stalled = 1'b0;
        if (stall_left > 0 && out_valid) begin
            stalled = 1'b1;
            stall_left = stall_left - 1;
        end
        in_valid  = v;
        in_data   = d;
        in_coef   = c;
        in_last   = l;
        out_ready = stalled ? 1'b0 : ordy;
        #1;
        if (stalled) check("stall_in_ready", in_ready, 0);
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (out_valid) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("out_data", longint'(out_data), exp_data_q[0]);
                check("out_err", out_err, exp_err_q[0]);
                if (out_ready) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
        end
        accepted = v && in_ready;
        if (accepted) model_tap(d, c, l);
    endtask

    task automatic send_tap(input logic signed [DATA_W-1:0] d, input logic signed [COEF_W-1:0] c,
                            input logic l);
        logic acc_f;
        int   guard;
        acc_f = 1'b0;
        guard = 0;
        while (!acc_f && guard < 50) begin
            step(1'b1, d, c, l, 1'b1, acc_f);
            guard++;
        end
        if (!acc_f) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc_f;
        for (int k = 0; k < 40; k++) begin
            if (exp_data_q.size() == 0 && !out_valid) break;
            step(1'b0, '0, '0, 1'b0, 1'b1, acc_f);
        end
        check("drain_empty", exp_data_q.size(), 0);
    endtask

    initial begin
        logic signed [DATA_W-1:0] da [18];
        logic signed [COEF_W-1:0] ca [18];
        logic acc_f;
        int   idx, guard, lat;
        logic signed [OUT_W-1:0] d3_seen;
        logic e3_seen;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_coef = '0; in_last = 1'b0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_data3 = '0; in_coef3 = '0; in_last3 = 1'b0; out_ready3 = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // TAPS=3, SHIFT=0 instance: 1*4+2*5+3*6 = 32, three cycles after the last tap.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid3 = 1'b1;
            in_data3  = 16'(i + 1);
            in_coef3  = 16'(i + 4);
            in_last3  = (i == 2);
        end
        lat = 0; d3_seen = '0; e3_seen = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid3 = 1'b0;
            in_last3  = 1'b0;
            #1;
            if (out_valid3 && lat == 0) begin
                lat = k;
                d3_seen = out_data3;
                e3_seen = out_err3;
            end
        end
        check("t3_latency", lat, 3);
        check("t3_data", longint'(d3_seen), 32);
        check("t3_err", e3_seen, 0);

        // Rounding: 384 -> 2 and -384 -> -1, sent back to back.
        for (int i = 0; i < 8; i++) send_tap(16'sd0, 16'sd0, 1'b0);
        send_tap(16'sd384, 16'sd1, 1'b1);
        for (int i = 0; i < 8; i++) send_tap(16'sd0, 16'sd0, 1'b0);
        send_tap(-16'sd384, 16'sd1, 1'b1);
        // Large sum: saturates or wraps depending on the build.
        for (int i = 0; i < 9; i++) send_tap(16'sd32767, 16'sd32767, i == 8);
        // Early last on the 5th tap, then a full group without last.
        for (int i = 0; i < 5; i++) send_tap(16'(i * 300), 16'sd7, i == 4);
        for (int i = 0; i < 9; i++) send_tap(16'(i * 1000 - 3000), -16'sd5, 1'b0);
        drain();

        // Back-to-back groups with a 4-cycle output stall on the first result.
        for (int i = 0; i < 18; i++) begin
            da[i] = 16'($urandom);
            ca[i] = 16'($urandom);
        end
        stall_left = 4;
        idx = 0;
        guard = 0;
        while (idx < 18 && guard < 200) begin
            step(1'b1, da[idx], ca[idx], (idx % 9) == 8, 1'b1, acc_f);
            if (acc_f) idx++;
            guard++;
        end
        check("stall_taps_sent", idx, 18);
        drain();
        check("stall_consumed", stall_left, 0);

        // Asynchronous reset mid-group discards the partial accumulation.
        for (int i = 0; i < 4; i++) send_tap(16'sd12345, 16'sd321, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", longint'(out_data), 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_in_ready", in_ready, 1);
        m_sum = 0;
        m_cnt = 0;
        exp_data_q.delete();
        exp_err_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) send_tap(16'(i * 11 + 5), 16'(200 - i * 37), i == 8);
        drain();

        // Randomized traffic with bubbles, random group lengths and random backpressure.
        for (int n = 0; n < 1500; n++) begin
            logic signed [DATA_W-1:0] rd;
            logic signed [COEF_W-1:0] rc;
            case ($urandom_range(0, 3))
                0: rd = 16'sd32767;
                1: rd = -16'sd32768;
                default: rd = 16'($urandom);
            endcase
            rc = ($urandom_range(0, 3) == 0) ? -16'sd32768 : 16'($urandom);
            step($urandom_range(0, 3) != 0, rd, rc, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, acc_f);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
